// File: rtl/mem_scan_reader_if.sv
// rtl/mem_scan_reader_if.sv - RAM read port and output stream bundle for mem_scan_reader
interface mem_scan_reader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 2
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_spo;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output mem_addr,
    input  mem_spo,
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  mem_addr,
    output mem_spo,
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/mem_scan_reader.sv
// rtl/mem_scan_reader.sv - streams a wrapped (base,len) window of a distributed RAM over valid/ready
// Optional SCAN_CHECKSUM_EN adds out_sum, the modulo-256 sum of accepted words.
module mem_scan_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  mem_scan_reader_if.master bus,
  output logic              busy,
  output logic              done
`ifdef SCAN_CHECKSUM_EN
  ,
  output logic [7:0]        out_sum
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic              free;
`ifdef SCAN_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  assign accept = valid_q & bus.out_ready;
  assign free   = ~valid_q | accept;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = (state_q == FIN);
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base;
          rem_d   = len;
          state_d = (len == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        // spo is asynchronous, so the word for addr_q is captured in the same cycle
        if (free) begin
          data_d  = bus.mem_spo;
          valid_d = 1'b1;
          last_d  = (rem_q == REM_ONE);
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = FIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN) || (state_d == DRAIN);
  end

`ifdef SCAN_CHECKSUM_EN
  always_comb begin
    sum_d = sum_q;
    if (state_q == IDLE && start) begin
      sum_d = '0;
    end else if (accept) begin
      sum_d = sum_q + 8'(data_q);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SCAN_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SCAN_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign busy          = busy_q;
  assign done          = done_q;
`ifdef SCAN_CHECKSUM_EN
  assign out_sum       = sum_q;
`endif

endmodule

// File: tb/tb_mem_scan_reader.sv
// tb/tb_mem_scan_reader.sv - scoreboard bench for mem_scan_reader (directed plan plus random scans)
module tb_mem_scan_reader;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 2;
  localparam int DEPTH  = 16;

  typedef struct packed {
    logic [1:0] d;
    logic       l;
  } beat_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [3:0] base  = '0;
  logic [4:0] len   = '0;
  logic       busy;
  logic       done;
`ifdef SCAN_CHECKSUM_EN
  logic [7:0] out_sum;
`endif
  logic [1:0] mem [DEPTH];
  logic       rdy = 1'b1;
  int         mode = 0;
  logic [5:0] pat = 6'b101001;
  int         pi = 0;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  beat_t exp_q[$];
  int    exp_sum_q[$];

  mem_scan_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  assign bus.mem_spo   = mem[bus.mem_addr];
  assign bus.out_ready = rdy;

  mem_scan_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .base  (base),
    .len   (len),
    .bus   (bus.master),
    .busy  (busy),
    .done  (done)
`ifdef SCAN_CHECKSUM_EN
    ,
    .out_sum (out_sum)
`endif
  );

  always #5 clk = ~clk;

  // consumer back-pressure: 0 = always ready, 1 = random, 2 = fixed 1,0,0,1,0,1 pattern
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = pat[pi];
          pi  = (pi + 1) % 6;
        end
      endcase
    end
  end

  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic       pl = 1'b0;
  logic [1:0] pd = '0;

  always @(negedge clk) begin : monitor
    beat_t e;
    int    s;
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        checks++;
        if (!(bus.out_valid === 1'b1 && bus.out_data === pd && bus.out_last === pl)) begin
          errors++;
          $display("FAIL stall_hold: valid=%0b data=%0d last=%0b, required valid=1 data=%0d last=%0b",
                   bus.out_valid, bus.out_data, bus.out_last, pd, pl);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        acc_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: data=%0d last=%0b, required no beat", bus.out_data, bus.out_last);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e.d || bus.out_last !== e.l) begin
            errors++;
            $display("FAIL beat: data=%0d last=%0b, required data=%0d last=%0b",
                     bus.out_data, bus.out_last, e.d, e.l);
          end
        end
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (exp_sum_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done=1, required 0");
        end else begin
          s = exp_sum_q.pop_front();
          if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_early: beats_left=%0d busy=%0b, required beats_left=0 busy=0",
                     exp_q.size(), busy);
          end
`ifdef SCAN_CHECKSUM_EN
          checks++;
          if (out_sum !== 8'(s)) begin
            errors++;
            $display("FAIL checksum: out_sum=%0d, required %0d", out_sum, s);
          end
`endif
        end
      end
      pv = bus.out_valid;
      pr = bus.out_ready;
      pd = bus.out_data;
      pl = bus.out_last;
    end
  end

  task automatic expect_window(input int b, input int l);
    beat_t e;
    int    s;
    s = 0;
    for (int i = 0; i < l; i++) begin
      e.d = mem[(b + i) % DEPTH];
      e.l = (i == l - 1);
      exp_q.push_back(e);
      s += int'(e.d);
    end
    exp_sum_q.push_back(s % 256);
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.mem_addr !== '0 || bus.out_data !== '0 || bus.out_valid !== 1'b0 ||
        bus.out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s: addr=%0d data=%0d valid=%0b last=%0b busy=%0b done=%0b, required all 0",
               name, bus.mem_addr, bus.out_data, bus.out_valid, bus.out_last, busy, done);
    end
`ifdef SCAN_CHECKSUM_EN
    checks++;
    if (out_sum !== 8'd0) begin
      errors++;
      $display("FAIL %s_sum: out_sum=%0d, required 0", name, out_sum);
    end
`endif
  endtask

  task automatic scan(input int b, input int l, input bit poke);
    int d0;
    expect_window(b, l);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b1;
    base  = 4'(b);
    len   = 5'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
    base  = 4'($urandom_range(0, 15));
    len   = 5'($urandom_range(0, 16));
    checks++;
    if (busy !== (l != 0)) begin
      errors++;
      $display("FAIL busy_after_start: busy=%0b, required %0b", busy, (l != 0));
    end
    if (l != 0) begin
      checks++;
      if (bus.mem_addr !== 4'(b)) begin
        errors++;
        $display("FAIL addr_latency: mem_addr=%0d, required %0d", bus.mem_addr, b);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (l == 0) begin
      if (done !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL len0: done=%0b busy=%0b valid=%0b, required done=1 busy=0 valid=0",
                 done, busy, bus.out_valid);
      end
    end else begin
      if (bus.out_valid !== 1'b1 || bus.out_data !== mem[b % DEPTH]) begin
        errors++;
        $display("FAIL first_beat: valid=%0b data=%0d, required valid=1 data=%0d",
                 bus.out_valid, bus.out_data, mem[b % DEPTH]);
      end
    end
    for (int t = 0; t < 400 && done_cnt == d0; t++) begin
      if (poke && t == 2) begin
        start = 1'b1;
        base  = 4'($urandom_range(0, 15));
        len   = 5'($urandom_range(1, 16));
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL done_timeout: done pulses=%0d, required %0d", done_cnt, d0 + 1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_done: busy=%0b done=%0b valid=%0b, required 0 0 0", busy, done, bus.out_valid);
    end
  endtask

  initial begin : stim
    int a0;
    int l;
    for (int i = 0; i < DEPTH; i++) mem[i] = 2'(i % 4);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst = 1'b0;

    mode = 0;
    scan(0, 16, 1'b1);
    scan(14, 4, 1'b0);
    mode = 2;
    pi   = 0;
    scan(3, 5, 1'b0);
    mode = 0;
    scan(5, 0, 1'b0);

    // reset in the middle of a full scan, then a short clean scan
    expect_window(0, 16);
    @(posedge clk);
    #1;
    start = 1'b1;
    base  = 4'd0;
    len   = 5'd16;
    @(posedge clk);
    #1;
    start = 1'b0;
    a0 = acc_cnt;
    for (int t = 0; t < 100 && acc_cnt < a0 + 5; t++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (acc_cnt < a0 + 5) begin
      errors++;
      $display("FAIL mid_scan_beats: accepted=%0d, required %0d", acc_cnt - a0, 5);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("mid_scan_reset");
    exp_q.delete();
    exp_sum_q.delete();
    rst = 1'b0;
    scan(0, 2, 1'b0);

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 2);
      l    = $urandom_range(0, 16);
      scan($urandom_range(0, 15), l, (l >= 8) && ($urandom_range(0, 1) == 1));
    end

    checks++;
    if (exp_q.size() != 0 || exp_sum_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: beats=%0d scans=%0d, required 0 0", exp_q.size(), exp_sum_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_scan_reader.md
Name: mem_scan_reader

Overview:
- Read-side streamer for the 16x2 distributed RAM used by the counter/RAM circuits.
- On a start command it walks a contiguous address window (base, len) through the RAM's asynchronous read port (spo).
- Each word is emitted on a registered valid/ready stream, so a downstream consumer (display, LED driver, checker) can drain memory contents at its own pace.
- Never writes the RAM; the counter-driven writer owns we/d.

Parameters:
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W.
- DATA_W, 2, RAM word width.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin scan; sampled only in IDLE.
- base  input  ADDR_W  first address of scan; sampled with start.
- len  input  ADDR_W+1  number of words, 0..2**ADDR_W; sampled with start.
- mem_addr  output  ADDR_W  address to RAM read port a (registered).
- mem_spo  input  DATA_W  asynchronous read data from RAM for mem_addr.
- out_data  output  DATA_W  stream data (registered).
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts when high with out_valid.
- out_last  output  1  high with out_valid on the final word of a scan.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the scan completes.

Behaviour:
- Reset (rst high at posedge): state=IDLE; mem_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0; checksum=0. Reset mid-scan aborts immediately, drops any held word, and starts no partial done.
- States:
  - IDLE -> RUN on start with len!=0. Latch addr=base and remaining=len. busy=1 next cycle.
  - IDLE -> FIN on start with len==0. No words emitted.
  - RUN: captures words as below. Goes to DRAIN when the last word has been captured into the output register.
  - DRAIN: holds until the last word is accepted (out_valid & out_ready & out_last), then -> FIN.
  - FIN: done=1 for exactly one cycle, busy=0, -> IDLE.
- Capture rule (RUN): the output register is "free" when out_valid==0 or (out_valid & out_ready).
  - When free: out_data<=mem_spo, out_valid<=1, out_last<=(remaining==1), mem_addr<=mem_addr+1 mod 2**ADDR_W, remaining<=remaining-1.
  - When not free: out_data, out_valid, out_last, mem_addr and remaining all hold. A stalled word is never lost or duplicated.
  - Full-rate: with out_ready tied high, one word per cycle.
- Latency: start accepted at cycle N. mem_addr=base at N+1. out_valid=1 with mem[base] at N+2.
- Accept with nothing new to capture clears out_valid and out_last.
- Address wrap: base+len > depth wraps to 0. len=2**ADDR_W reads every location exactly once.
- start while busy, DRAIN or FIN: ignored, with no effect on the latched window.
- RAM contents changing mid-scan: the word captured reflects spo at capture cycle; no coherency guarantee.
- out_data, out_valid and out_last are stable while out_valid & !out_ready.

Optional Feature:
- Macro SCAN_CHECKSUM_EN.
- When defined:
  - Adds output out_sum [7:0], the modulo-256 sum of every word accepted (out_valid & out_ready) during the current scan.
  - Cleared to 0 when start is accepted.
  - Final value stable from the done cycle until the next accepted start.
  - Reset value 0.
- When undefined: port and adder are absent; all other behaviour is identical.

Test Plan:
- RAM preloaded mem[i]=i%4, start base=0 len=16, out_ready=1 -> 16 consecutive beats 0,1,2,3,0,...,3. out_last only on beat 16. First beat 2 cycles after start. done 1 cycle after last beat. busy low afterwards.
- base=14 len=4 -> mem_addr sequence 14,15,0,1; data 2,3,0,1; out_last on data 1.
- base=3 len=5, out_ready toggled 1,0,0,1,0,1... -> data 3,0,1,2,3 in order with no drops or duplicates. out_data and out_valid hold during every stall.
- start with len=0 -> no out_valid. done pulses 2 cycles after start, and busy never rises.
- rst asserted mid-scan of len=16 after 5 beats -> next cycle all outputs 0 and state IDLE. A new start base=0 len=2 then emits 0,1 normally.
- SCAN_CHECKSUM_EN defined, full 16-word scan with mem[i]=i%4 -> out_sum=24 at done. A start during the scan is ignored and out_sum is unaffected.
